cpu_clk_stepper: RTL and testbench
==================================

Name: cpu_clk_stepper

Overview:
- Generates the processor clock `cpu_clk` from the board clock. Sits directly upstream of the single-cycle CPU core, in place of the plain clock divider.
- Two modes, selected by a switch: free-run (divided clock) and single-step (one clean `cpu_clk` pulse per debounced button press).
- Also counts issued CPU clock edges for display and debug.

Parameters:
- DIV_HALF, 50000000: free-run half-period in clk cycles; cpu_clk period = 2*DIV_HALF.
- DEBOUNCE_CYCLES, 1000000: number of consecutive cycles the button must differ from its debounced level before that level changes.
- STEP_HIGH, 1000: cpu_clk high width in clk cycles for a single step.

Ports:
- clk  input  1  board clock.
- reset  input  1  asynchronous, active-high.
- step_btn  input  1  raw, asynchronous, bouncing push-button.
- run_sw  input  1  raw, asynchronous mode switch; 1 = free-run, 0 = single-step.
- cpu_clk  output  1  registered, glitch-free CPU clock.
- running  output  1  high while in RUN state.
- edge_count  output  16  count of cpu_clk rising edges issued; wraps.

Behaviour:
- Reset (asynchronous, active-high), all values forced while reset is high:
  - cpu_clk=0, running=0, edge_count=0, state=IDLE.
  - Synchronizer flops, debounced level and all counters = 0.
- Input synchronization:
  - step_btn and run_sw each pass through a 2-flop synchronizer.
  - Every downstream decision uses the synchronized values (btn_s, run_s).
- Debounce:
  - Counter db_cnt increments each cycle that btn_s != btn_db.
  - Counter clears on any cycle that btn_s == btn_db.
  - When btn_s != btn_db and db_cnt == DEBOUNCE_CYCLES-1: btn_db <= btn_s and db_cnt <= 0.
  - step_req is a 1-cycle registered pulse on a 0->1 change of btn_db.
  - Bounces shorter than DEBOUNCE_CYCLES produce no step_req.
  - A button held through reset yields exactly one step_req once debounced.
- FSM states:
  - IDLE: cpu_clk=0.
    - run_s=1 -> RUN, with div_cnt cleared. run_s has priority over step_req in the same cycle.
    - Otherwise step_req=1 -> STEP_HI; cpu_clk goes 1 on the next cycle edge.
  - STEP_HI: cpu_clk=1, hi_cnt counts 0..STEP_HIGH-1.
    - On the last count -> IDLE with cpu_clk=0.
    - step_req and run_s are ignored during this state; a dropped step is not queued.
  - RUN: cpu_clk starts 0 and div_cnt counts 0..DIV_HALF-1.
    - On the last count cpu_clk toggles and div_cnt resets.
    - step_req is ignored.
    - If run_s=0 while cpu_clk=0 -> IDLE immediately.
    - If run_s=0 while cpu_clk=1 -> stay in RUN until the current high phase completes its full DIV_HALF cycles, then -> IDLE with cpu_clk=0. No runt high pulse.
- Clock pulse width guarantees:
  - Every cpu_clk high pulse is exactly STEP_HIGH (step) or DIV_HALF (run) cycles.
  - Every low phase is at least 1 cycle.
- running = (state == RUN), registered.
- edge_count:
  - Increments by 1 on the clk edge at which cpu_clk transitions 0->1.
  - Modulo 2^16; 0xFFFF wraps to 0x0000.
- Reset asserted mid-pulse: cpu_clk drops to 0 asynchronously and no further edge is produced until reset is released.

Test Plan (DIV_HALF=4, DEBOUNCE_CYCLES=8, STEP_HIGH=3):
- Reset, run_sw=0, step_btn=0 for 100 cycles -> cpu_clk=0, edge_count=0, running=0 throughout.
- Clean press of step_btn held 30 cycles -> exactly one cpu_clk high pulse of width 3. It rises 2+8+1+1 = 12 cycles after the press reaches clk. edge_count=1.
- Press bouncing (toggle every 3 cycles for 20 cycles), then stable high -> exactly one pulse, edge_count=1. A second clean press -> edge_count=2.
- run_sw=1 for 80 cycles -> running=1, cpu_clk period 8 (4 high / 4 low), edge_count=10 (±1 for the start phase). Button presses during RUN change nothing.
- run_sw dropped 1 cycle after a cpu_clk rising edge -> cpu_clk stays high the full 4 cycles, then 0, running=0, no further edges.
- Preload edge_count=0xFFFF via 65535 run edges (or a forced state), then one more edge -> edge_count=0x0000. Assert reset mid-high-pulse -> cpu_clk=0 immediately and all outputs return to 0.

Source files
------------

// File: rtl/cpu_clk_stepper.sv
// CPU clock source: free-running divider or debounced single-step pulses,
// with a wrapping count of issued cpu_clk rising edges.
module cpu_clk_stepper #(
  parameter int DIV_HALF        = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int STEP_HIGH       = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step_btn,
  input  logic        run_sw,
  output logic        cpu_clk,
  output logic        running,
  output logic [15:0] edge_count
);

  localparam int DBW  = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIVW = ($clog2(DIV_HALF) > 0) ? $clog2(DIV_HALF) : 1;
  localparam int HIW  = ($clog2(STEP_HIGH) > 0) ? $clog2(STEP_HIGH) : 1;

  typedef enum logic [1:0] {IDLE, STEP_HI, RUN} state_e;

  logic            btn_m_q, btn_s_q, run_m_q, run_s_q;
  logic            btn_db_q, btn_db_d, btn_db_prev_q, step_req_q;
  logic [DBW-1:0]  db_cnt_q, db_cnt_d;
  state_e          state_q, state_d;
  logic            cpu_clk_q, cpu_clk_d, running_q;
  logic [DIVW-1:0] div_cnt_q, div_cnt_d;
  logic [HIW-1:0]  hi_cnt_q, hi_cnt_d;
  logic [15:0]     edge_count_q, edge_count_d;
  logic            div_last, hi_last;

  // Two-flop synchronizers for both raw asynchronous inputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_m_q <= 1'b0;
      btn_s_q <= 1'b0;
      run_m_q <= 1'b0;
      run_s_q <= 1'b0;
    end else begin
      btn_m_q <= step_btn;
      btn_s_q <= btn_m_q;
      run_m_q <= run_sw;
      run_s_q <= run_m_q;
    end
  end

  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (btn_s_q != btn_db_q) begin
      if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) btn_db_d = btn_s_q;
      else                                       db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // step_req fires one cycle after the debounced level rises
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      db_cnt_q      <= '0;
      step_req_q    <= 1'b0;
    end else begin
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_q;
      db_cnt_q      <= db_cnt_d;
      step_req_q    <= btn_db_q & ~btn_db_prev_q;
    end
  end

  assign div_last = (div_cnt_q == DIVW'(DIV_HALF - 1));
  assign hi_last  = (hi_cnt_q == HIW'(STEP_HIGH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cpu_clk_q    <= 1'b0;
      running_q    <= 1'b0;
      div_cnt_q    <= '0;
      hi_cnt_q     <= '0;
      edge_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cpu_clk_q    <= cpu_clk_d;
      running_q    <= (state_d == RUN);
      div_cnt_q    <= div_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      edge_count_q <= edge_count_d;
    end
  end

  // Leaving RUN waits for a high phase to finish so no runt pulse is issued
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (run_s_q)         state_d = RUN;
        else if (step_req_q) state_d = STEP_HI;
      end
      STEP_HI: if (hi_last) state_d = IDLE;
      RUN:     if (!run_s_q && (!cpu_clk_q || div_last)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_clk_d = 1'b0;
    div_cnt_d = '0;
    hi_cnt_d  = '0;
    unique case (state_q)
      IDLE: if (!run_s_q && step_req_q) cpu_clk_d = 1'b1;
      STEP_HI: begin
        if (!hi_last) begin
          cpu_clk_d = 1'b1;
          hi_cnt_d  = hi_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (state_d == RUN) begin
          if (div_last) begin
            cpu_clk_d = ~cpu_clk_q;
          end else begin
            cpu_clk_d = cpu_clk_q;
            div_cnt_d = div_cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
    edge_count_d = edge_count_q + {15'd0, cpu_clk_d & ~cpu_clk_q};
  end

  assign cpu_clk    = cpu_clk_q;
  assign running    = running_q;
  assign edge_count = edge_count_q;

endmodule

// File: tb/tb_cpu_clk_stepper.sv
// Directed bench for cpu_clk_stepper with small timing parameters
// (DIV_HALF=4, DEBOUNCE_CYCLES=8, STEP_HIGH=3).
module tb_cpu_clk_stepper;

  logic        clk = 1'b0;
  logic        reset, step_btn, run_sw;
  logic        cpu_clk, running;
  logic [15:0] edge_count;

  int tests = 0;
  int fails = 0;

  int w_rises, w_highs, w_first, w_minhi, w_maxhi, w_mingap, w_maxgap, w_run;

  cpu_clk_stepper #(.DIV_HALF(4), .DEBOUNCE_CYCLES(8), .STEP_HIGH(3)) dut (
    .clk(clk), .reset(reset), .step_btn(step_btn), .run_sw(run_sw),
    .cpu_clk(cpu_clk), .running(running), .edge_count(edge_count)
  );

  always #5 clk = ~clk;

  // Observe n cycles at negedges: rises, high cycles, first rise index,
  // completed high-pulse widths, rise-to-rise gaps, cycles with running=1.
  task automatic watch(input int n);
    int   run_len, last_rise;
    logic prev;
    w_rises = 0; w_highs = 0; w_first = -1; w_run = 0;
    w_minhi = 1 << 30; w_maxhi = 0; w_mingap = 1 << 30; w_maxgap = 0;
    run_len = 0; last_rise = -1; prev = cpu_clk;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (running) w_run++;
      if (cpu_clk) begin
        w_highs++;
        run_len++;
      end else if (prev) begin
        if (run_len < w_minhi) w_minhi = run_len;
        if (run_len > w_maxhi) w_maxhi = run_len;
        run_len = 0;
      end
      if (cpu_clk && !prev) begin
        w_rises++;
        if (w_first < 0) w_first = i;
        if (last_rise >= 0) begin
          if (i - last_rise < w_mingap) w_mingap = i - last_rise;
          if (i - last_rise > w_maxgap) w_maxgap = i - last_rise;
        end
        last_rise = i;
      end
      prev = cpu_clk;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; run_sw = 1'b0; step_btn = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; run_sw = 1'b0; step_btn = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({cpu_clk, running, edge_count} !== 18'd0) begin
      fails++; $display("FAIL reset_outputs: got clk=%0b run=%0b ec=%0d expected all 0", cpu_clk, running, edge_count);
    end
    reset = 1'b0;
    watch(100);
    tests++;
    if (w_highs !== 0 || w_run !== 0) begin
      fails++; $display("FAIL reset_idle_quiet: got highs=%0d running_cycles=%0d expected 0/0", w_highs, w_run);
    end
    tests++;
    if (edge_count !== 16'd0) begin
      fails++; $display("FAIL reset_idle_count: got %0d expected 0", edge_count);
    end
  endtask

  task automatic test_clean_step();
    do_reset();
    @(negedge clk);
    step_btn = 1'b1;
    fork
      watch(50);
      begin repeat (30) @(negedge clk); step_btn = 1'b0; end
    join
    tests++;
    if (w_rises !== 1 || w_first !== 12) begin
      fails++; $display("FAIL step_latency: got rises=%0d first=%0d expected 1/12", w_rises, w_first);
    end
    tests++;
    if (w_minhi !== 3 || w_maxhi !== 3) begin
      fails++; $display("FAIL step_width: got min=%0d max=%0d expected 3/3", w_minhi, w_maxhi);
    end
    tests++;
    if (edge_count !== 16'd1) begin
      fails++; $display("FAIL step_count: got %0d expected 1", edge_count);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    @(negedge clk);
    fork
      watch(75);
      begin
        for (int i = 0; i < 20; i++) begin
          step_btn = ((i / 3) % 2) == 0;
          @(negedge clk);
        end
        step_btn = 1'b1;
        repeat (30) @(negedge clk);
        step_btn = 1'b0;
      end
    join
    tests++;
    if (w_rises !== 1 || edge_count !== 16'd1) begin
      fails++; $display("FAIL bounce_single: got rises=%0d ec=%0d expected 1/1", w_rises, edge_count);
    end
    @(negedge clk);
    step_btn = 1'b1;
    fork
      watch(50);
      begin repeat (30) @(negedge clk); step_btn = 1'b0; end
    join
    tests++;
    if (w_rises !== 1 || edge_count !== 16'd2) begin
      fails++; $display("FAIL second_press: got rises=%0d ec=%0d expected 1/2", w_rises, edge_count);
    end
  endtask

  task automatic test_run();
    do_reset();
    @(negedge clk);
    run_sw = 1'b1;
    fork
      watch(80);
      begin
        repeat (10) @(negedge clk); step_btn = 1'b1;
        repeat (30) @(negedge clk); step_btn = 1'b0;
      end
    join
    tests++;
    if (w_rises !== 10 || w_first !== 7 || edge_count !== 16'd10) begin
      fails++; $display("FAIL run_edges: got rises=%0d first=%0d ec=%0d expected 10/7/10", w_rises, w_first, edge_count);
    end
    tests++;
    if (w_minhi !== 4 || w_maxhi !== 4 || w_mingap !== 8 || w_maxgap !== 8) begin
      fails++; $display("FAIL run_shape: got hi=%0d..%0d period=%0d..%0d expected 4/4 8/8", w_minhi, w_maxhi, w_mingap, w_maxgap);
    end
    tests++;
    if (w_run !== 78 || running !== 1'b1) begin
      fails++; $display("FAIL run_flag: got cycles=%0d running=%0b expected 78/1", w_run, running);
    end
  endtask

  task automatic test_run_stop();
    logic found, p;
    int   ec;
    found = 1'b0;
    p = cpu_clk;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (cpu_clk && !p) found = 1'b1;
      p = cpu_clk;
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL stop_wait_rise: got no rising edge expected one within 20 cycles");
    end
    ec = edge_count;
    run_sw = 1'b0;
    watch(30);
    tests++;
    if (w_highs !== 3 || w_rises !== 0) begin
      fails++; $display("FAIL stop_no_runt: got highs=%0d rises=%0d expected 3/0", w_highs, w_rises);
    end
    tests++;
    if (w_run !== 3 || running !== 1'b0 || edge_count !== 16'(ec)) begin
      fails++; $display("FAIL stop_idle: got run_cycles=%0d running=%0b ec=%0d expected 3/0/%0d", w_run, running, edge_count, ec);
    end
  endtask

  task automatic test_wrap_and_reset();
    logic found;
    do_reset();
    @(negedge clk);
    force dut.edge_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.edge_count_q;
    step_btn = 1'b1;
    fork
      watch(30);
      begin repeat (20) @(negedge clk); step_btn = 1'b0; end
    join
    tests++;
    if (w_rises !== 1 || edge_count !== 16'h0000) begin
      fails++; $display("FAIL wrap: got rises=%0d ec=%0h expected 1/0000", w_rises, edge_count);
    end
    repeat (15) @(negedge clk);
    step_btn = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (cpu_clk) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL reset_mid_wait: got no pulse expected one within 30 cycles");
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests++;
    if ({cpu_clk, running, edge_count} !== 18'd0) begin
      fails++; $display("FAIL reset_mid_pulse: got clk=%0b run=%0b ec=%0d expected all 0", cpu_clk, running, edge_count);
    end
    repeat (5) @(negedge clk);
    reset = 1'b0;
    watch(40);
    tests++;
    if (w_rises !== 1 || w_first !== 12 || edge_count !== 16'd1) begin
      fails++; $display("FAIL held_through_reset: got rises=%0d first=%0d ec=%0d expected 1/12/1", w_rises, w_first, edge_count);
    end
    step_btn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_bounce();
    test_run();
    test_run_stop();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
